rgb_led_scheduler: RTL and testbench
====================================

// Module: rgb_led_scheduler
//
// PURPOSE
//   Controls the SB_RGBA_DRV RGB LED driver and shares it between two requesters.
//   - Sequences driver power-up: CURREN first, then RGBLEDEN after a settle time.
//   - Arbitrates a high-priority and a low-priority colour request.
//   - Generates the three PWM inputs (RGB0PWM red, RGB1PWM green, RGB2PWM blue).
//   - Powers the driver back down after an idle timeout.
//
// PARAMETERS
//   PWM_W        8     PWM duty/counter width; one PWM period = 2**PWM_W ticks
//   PRESCALE     64    hw_clk cycles per PWM tick (>=1)
//   WARMUP_CYC   4096  hw_clk cycles between curren rise and rgbleden rise
//   IDLE_PERIODS 256   PWM periods with no request before powering down
//
// PORTS
//   hw_clk     in   1          board oscillator clock, sole clock
//   rst_n      in   1          async active-low reset
//   req_hi     in   1          high-priority request, level; hold until done
//   color_hi   in   3*PWM_W    {red,green,blue} duty for requester hi
//   req_lo     in   1          low-priority request, level
//   color_lo   in   3*PWM_W    {red,green,blue} duty for requester lo
//   gnt_hi     out  1          requester hi currently owns the LED
//   gnt_lo     out  1          requester lo currently owns the LED
//   curren     out  1          to SB_RGBA_DRV CURREN
//   rgbleden   out  1          to SB_RGBA_DRV RGBLEDEN
//   pwm_red    out  1          to RGB0PWM
//   pwm_green  out  1          to RGB1PWM
//   pwm_blue   out  1          to RGB2PWM
//   ready      out  1          driver powered and enabled (state IDLE or SHOW)
//
// BEHAVIOUR
//   Reset
//   - rst_n low clears all outputs, counters and state to 0/OFF, asynchronously.
//   - Reset mid-SHOW drops all PWM outputs and grants immediately.
//   Timebase
//   - Prescaler emits a 1-cycle tick every PRESCALE clocks.
//   - pwm_cnt (PWM_W bits) increments on each tick and wraps at 2**PWM_W-1.
//   - Boundary = the tick on which pwm_cnt wraps to 0.
//   - Prescaler and pwm_cnt run only outside OFF.
//   FSM
//   - OFF: curren=0, rgbleden=0.
//     - Either req high -> WARMUP, and curren=1 from the next cycle.
//   - WARMUP: curren=1; counts WARMUP_CYC clocks.
//     - Then -> IDLE, with rgbleden=1 and ready=1.
//     - A request dropping during WARMUP does not abort it.
//   - IDLE: PWM outputs 0, no grant.
//     - At a boundary with any req high -> SHOW, granting by priority.
//     - IDLE_PERIODS consecutive boundaries with no req -> OFF.
//     - rgbleden and curren fall in the same cycle.
//     - Idle count clears on entering IDLE.
//   - SHOW: exactly one gnt high.
//   Arbitration (evaluated only at boundaries)
//   - req_hi wins over req_lo.
//   - A hi request preempts a lo owner at the next boundary.
//   - Lo never preempts hi.
//   - If the owner's req is low at a boundary: grant passes to the other requester if it is requesting, else -> IDLE.
//   - Both requests rising in the same cycle -> hi granted.
//   Colour and PWM
//   - The owner's colour is latched into duty registers at every boundary while granted.
//   - Mid-period colour changes take effect only at the next boundary (glitch-free).
//   - pwm_x registered = (pwm_cnt < duty_x), so latency is 1 clock from the counter.
//   - duty 0 -> constant 0.
//   - duty 2**PWM_W-1 -> high for 2**PWM_W-1 of 2**PWM_W ticks.
//   - gnt_* changes in the clock after the boundary tick, aligned with the new duty.
//   - PWM outputs are forced 0 whenever rgbleden=0.
//
// TESTING
//   1. Reset, then req_lo=1 color_lo=0x804000:
//      - curren rises next cycle; rgbleden rises WARMUP_CYC cycles later.
//      - gnt_lo rises at the first boundary after that.
//      - red high 128/256 ticks, green 64/256, blue always 0.
//   2. req_lo owning, req_hi=1 raised mid-period:
//      - lo colour continues to the boundary.
//      - gnt_lo->0 and gnt_hi->1 in the same cycle after the boundary; hi duty from there.
//   3. req_hi owning, req_lo raised then req_hi dropped:
//      - grant passes to lo at the next boundary, never before.
//   4. All requests dropped:
//      - IDLE; after exactly IDLE_PERIODS boundaries curren=rgbleden=0.
//      - A request one boundary earlier cancels the power-down.
//   5. Duty extremes 0x00 and 0xFF, plus a colour change mid-period:
//      - pulse widths 0 and 255 ticks; the change is applied only at the boundary.
//   6. rst_n asserted mid-SHOW and mid-WARMUP:
//      - all outputs 0 asynchronously; after release, restart from OFF.

Source files
------------

// File: rtl/rgb_led_scheduler_if.sv
// Request/grant bundle shared by the two LED requesters and the scheduler.
interface rgb_led_scheduler_if #(
  parameter int PWM_W = 8
);
  logic               req_hi;
  logic [3*PWM_W-1:0] color_hi;
  logic               req_lo;
  logic [3*PWM_W-1:0] color_lo;
  logic               gnt_hi;
  logic               gnt_lo;

  modport master (
    output req_hi, color_hi, req_lo, color_lo,
    input  gnt_hi, gnt_lo
  );

  modport slave (
    input  req_hi, color_hi, req_lo, color_lo,
    output gnt_hi, gnt_lo
  );
endinterface

// File: rtl/rgb_led_scheduler.sv
// Power sequencing, two-way priority arbitration and PWM generation for the
// SB_RGBA_DRV RGB LED driver.
module rgb_led_scheduler #(
  parameter int PWM_W        = 8,
  parameter int PRESCALE     = 64,
  parameter int WARMUP_CYC   = 4096,
  parameter int IDLE_PERIODS = 256
) (
  input  logic                hw_clk,
  input  logic                rst_n,
  rgb_led_scheduler_if.slave  bus,
  output logic                curren,
  output logic                rgbleden,
  output logic                pwm_red,
  output logic                pwm_green,
  output logic                pwm_blue,
  output logic                ready
);

  localparam int PRE_W  = (PRESCALE > 1)     ? $clog2(PRESCALE)     : 1;
  localparam int WARM_W = (WARMUP_CYC > 1)   ? $clog2(WARMUP_CYC)   : 1;
  localparam int IDLE_W = (IDLE_PERIODS > 1) ? $clog2(IDLE_PERIODS) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_PERIODS - 1);
  localparam logic [PWM_W-1:0]  CNT_LAST  = '1;

  typedef enum logic [1:0] {OFF, WARMUP, IDLE, SHOW} state_t;

  state_t             state, state_nx;
  logic [PRE_W-1:0]   pre_cnt;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [WARM_W-1:0]  warm_cnt, warm_cnt_nx;
  logic [IDLE_W-1:0]  idle_cnt, idle_cnt_nx;
  logic               owner_hi, owner_hi_nx;
  logic [3*PWM_W-1:0] duty, duty_nx;
  logic               tick;
  logic               boundary;
  logic [2:0]         pwm_q;

  assign tick     = (state != OFF) && (pre_cnt == PRE_LAST);
  assign boundary = tick && (pwm_cnt == CNT_LAST);

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (state == OFF) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      warm_cnt <= '0;
      idle_cnt <= '0;
      owner_hi <= 1'b0;
      duty     <= '0;
    end else begin
      state    <= state_nx;
      warm_cnt <= warm_cnt_nx;
      idle_cnt <= idle_cnt_nx;
      owner_hi <= owner_hi_nx;
      duty     <= duty_nx;
    end
  end

  // Arbitration and colour latching happen only at period boundaries, so a
  // period is never cut short and duty changes are glitch-free.
  always_comb begin
    state_nx    = state;
    warm_cnt_nx = warm_cnt;
    idle_cnt_nx = idle_cnt;
    owner_hi_nx = owner_hi;
    duty_nx     = duty;
    case (state)
      OFF: begin
        warm_cnt_nx = '0;
        if (bus.req_hi || bus.req_lo) begin
          state_nx = WARMUP;
        end
      end
      WARMUP: begin
        if (warm_cnt == WARM_LAST) begin
          state_nx    = IDLE;
          idle_cnt_nx = '0;
        end else begin
          warm_cnt_nx = warm_cnt + 1'b1;
        end
      end
      IDLE, SHOW: begin
        if (boundary) begin
          if (bus.req_hi) begin
            state_nx    = SHOW;
            owner_hi_nx = 1'b1;
            duty_nx     = bus.color_hi;
          end else if (bus.req_lo) begin
            state_nx    = SHOW;
            owner_hi_nx = 1'b0;
            duty_nx     = bus.color_lo;
          end else if (state == SHOW) begin
            state_nx    = IDLE;
            idle_cnt_nx = '0;
            duty_nx     = '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state_nx = OFF;
          end else begin
            idle_cnt_nx = idle_cnt + 1'b1;
          end
        end
      end
      default: state_nx = OFF;
    endcase
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else if (state == SHOW) begin
      pwm_q <= {pwm_cnt < duty[3*PWM_W-1 -: PWM_W],
                pwm_cnt < duty[2*PWM_W-1 -: PWM_W],
                pwm_cnt < duty[PWM_W-1 -: PWM_W]};
    end else begin
      pwm_q <= '0;
    end
  end

  // Gating with SHOW blanks the stale registered sample when leaving SHOW.
  assign pwm_red    = pwm_q[2] & (state == SHOW);
  assign pwm_green  = pwm_q[1] & (state == SHOW);
  assign pwm_blue   = pwm_q[0] & (state == SHOW);

  assign curren     = (state != OFF);
  assign rgbleden   = (state == IDLE) || (state == SHOW);
  assign ready      = rgbleden;
  assign bus.gnt_hi = (state == SHOW) && owner_hi;
  assign bus.gnt_lo = (state == SHOW) && !owner_hi;

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Directed bench for rgb_led_scheduler with a timeline-based reference model
// compared against the outputs every cycle.
module tb_rgb_led_scheduler;

  localparam int PWM_W        = 8;
  localparam int PRESCALE     = 2;
  localparam int WARMUP_CYC   = 20;
  localparam int IDLE_PERIODS = 3;
  localparam int PERIOD       = PRESCALE * 256;

  localparam int M_OFF  = 0;
  localparam int M_WARM = 1;
  localparam int M_IDLE = 2;
  localparam int M_SHOW = 3;

  logic hw_clk = 1'b0;
  logic rst_n  = 1'b1;
  logic curren, rgbleden, pwm_red, pwm_green, pwm_blue, ready;
  logic [7:0] out_vec;

  int checks = 0;
  int errors = 0;

  int m_st = M_OFF;
  int m_k = 0;
  int m_idle = 0;
  bit m_owner_hi = 1'b0;
  int m_duty_r = 0;
  int m_duty_g = 0;
  int m_duty_b = 0;
  bit [2:0] m_pwm = 3'b000;

  rgb_led_scheduler_if #(.PWM_W(PWM_W)) bus ();

  rgb_led_scheduler #(
    .PWM_W(PWM_W), .PRESCALE(PRESCALE),
    .WARMUP_CYC(WARMUP_CYC), .IDLE_PERIODS(IDLE_PERIODS)
  ) dut (
    .hw_clk(hw_clk), .rst_n(rst_n), .bus(bus.slave),
    .curren(curren), .rgbleden(rgbleden),
    .pwm_red(pwm_red), .pwm_green(pwm_green), .pwm_blue(pwm_blue),
    .ready(ready)
  );

  assign out_vec = {curren, rgbleden, ready, bus.gnt_hi, bus.gnt_lo,
                    pwm_red, pwm_green, pwm_blue};

  always #5 hw_clk = ~hw_clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rh, input logic [23:0] ch,
                               input logic rl, input logic [23:0] cl);
    bus.req_hi   = rh;
    bus.color_hi = ch;
    bus.req_lo   = rl;
    bus.color_lo = cl;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge hw_clk);
      #1;
    end
  endtask

  task automatic count_pulses(input int n, output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    repeat (n) begin
      step(1);
      r += int'(pwm_red);
      g += int'(pwm_green);
      b += int'(pwm_blue);
    end
  endtask

  task automatic wait_grant(input bit hi, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (((hi ? bus.gnt_hi : bus.gnt_lo) == 1'b0) && n < 1000);
  endtask

  function automatic logic [7:0] model_vec();
    bit on, en, show;
    on   = (m_st != M_OFF);
    en   = (m_st == M_IDLE) || (m_st == M_SHOW);
    show = (m_st == M_SHOW);
    return {on, en, en, show && m_owner_hi, show && !m_owner_hi, m_pwm};
  endfunction

  // Timeline model: m_k counts cycles since power-on; PWM position and
  // boundaries follow from it arithmetically.
  task automatic model_step();
    int cnt;
    bit bnd;
    bit [2:0] nxt;
    cnt = (m_k / PRESCALE) % 256;
    bnd = (m_st != M_OFF) && ((m_k % PERIOD) == PERIOD - 1);
    nxt = (m_st == M_SHOW) ? {cnt < m_duty_r, cnt < m_duty_g, cnt < m_duty_b} : 3'b000;
    case (m_st)
      M_OFF: if (bus.req_hi || bus.req_lo) begin m_st = M_WARM; m_k = 0; end
      M_WARM: begin
        if (m_k == WARMUP_CYC - 1) begin m_st = M_IDLE; m_idle = 0; end
        m_k++;
      end
      default: begin
        if (bnd) begin
          if (bus.req_hi) begin
            m_st = M_SHOW; m_owner_hi = 1'b1;
            m_duty_r = int'(bus.color_hi[23:16]);
            m_duty_g = int'(bus.color_hi[15:8]);
            m_duty_b = int'(bus.color_hi[7:0]);
          end else if (bus.req_lo) begin
            m_st = M_SHOW; m_owner_hi = 1'b0;
            m_duty_r = int'(bus.color_lo[23:16]);
            m_duty_g = int'(bus.color_lo[15:8]);
            m_duty_b = int'(bus.color_lo[7:0]);
          end else if (m_st == M_SHOW) begin
            m_st = M_IDLE; m_idle = 0;
          end else if (m_idle == IDLE_PERIODS - 1) begin
            m_st = M_OFF;
          end else begin
            m_idle++;
          end
        end
        m_k++;
      end
    endcase
    m_pwm = (m_st == M_SHOW) ? nxt : 3'b000;
  endtask

  always @(negedge hw_clk) begin
    if (!rst_n) begin
      m_st = M_OFF; m_k = 0; m_idle = 0; m_owner_hi = 1'b0;
      m_duty_r = 0; m_duty_g = 0; m_duty_b = 0; m_pwm = 3'b000;
      checkOutput("reset_outputs", int'(out_vec), 0);
    end else begin
      checkOutput("model_outputs", int'(out_vec), int'(model_vec()));
      model_step();
    end
  end

  initial begin
    int r, g, b, n;
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    #2 rst_n = 1'b0;
    step(2);
    checkOutput("reset_vec", int'(out_vec), 0);
    rst_n = 1'b1;
    step(1);
    checkOutput("off_without_req", int'(curren), 0);

    // Power-up and first lo grant
    applyStimulus(1'b0, 24'h0, 1'b1, 24'h804000);
    step(1);
    checkOutput("curren_rise", int'(curren), 1);
    checkOutput("rgbleden_low_warmup", int'(rgbleden), 0);
    step(19);
    checkOutput("rgbleden_before_settle", int'(rgbleden), 0);
    step(1);
    checkOutput("rgbleden_after_settle", int'(rgbleden), 1);
    checkOutput("ready_after_settle", int'(ready), 1);
    step(491);
    checkOutput("gnt_lo_before_boundary", int'(bus.gnt_lo), 0);
    step(1);
    checkOutput("gnt_lo_at_boundary", int'(bus.gnt_lo), 1);
    count_pulses(512, r, g, b);
    checkOutput("red_half", r, 256);
    checkOutput("green_quarter", g, 128);
    checkOutput("blue_zero", b, 0);

    // Hi preempts lo at the next boundary
    step(100);
    applyStimulus(1'b1, 24'h10FF00, 1'b1, 24'h804000);
    step(1);
    checkOutput("lo_keeps_midperiod", int'(bus.gnt_lo), 1);
    checkOutput("hi_waits_midperiod", int'(bus.gnt_hi), 0);
    wait_grant(1'b1, n);
    checkOutput("preempt_latency", n, 411);
    checkOutput("lo_dropped_with_hi", int'(bus.gnt_lo), 0);

    // Hi drops, lo takes over only at the boundary
    applyStimulus(1'b1, 24'h10FF00, 1'b0, 24'h804000);
    step(50);
    applyStimulus(1'b1, 24'h10FF00, 1'b1, 24'h804000);
    step(50);
    applyStimulus(1'b0, 24'h10FF00, 1'b1, 24'h804000);
    step(1);
    checkOutput("hi_keeps_after_drop", int'(bus.gnt_hi), 1);
    checkOutput("lo_not_yet", int'(bus.gnt_lo), 0);
    wait_grant(1'b0, n);
    checkOutput("handover_latency", n, 411);
    checkOutput("hi_released", int'(bus.gnt_hi), 0);

    // Idle timeout, cancelled once, then taken
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h804000);
    step(512);
    checkOutput("idle_no_grant", int'(bus.gnt_lo), 0);
    checkOutput("idle_ready", int'(ready), 1);
    step(1024);
    checkOutput("idle_two_boundaries_on", int'(curren), 1);
    step(200);
    applyStimulus(1'b0, 24'h0, 1'b1, 24'h804000);
    step(312);
    checkOutput("cancel_powerdown_grant", int'(bus.gnt_lo), 1);
    checkOutput("cancel_powerdown_curren", int'(curren), 1);
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h804000);
    step(512);
    checkOutput("back_to_idle", int'(bus.gnt_lo), 0);
    step(1535);
    checkOutput("curren_before_timeout", int'(curren), 1);
    checkOutput("rgbleden_before_timeout", int'(rgbleden), 1);
    step(1);
    checkOutput("curren_timeout", int'(curren), 0);
    checkOutput("rgbleden_timeout", int'(rgbleden), 0);

    // Duty extremes and a mid-period colour change
    applyStimulus(1'b0, 24'h0, 1'b1, 24'h00FF80);
    step(1);
    checkOutput("repower_curren", int'(curren), 1);
    step(512);
    checkOutput("repower_grant", int'(bus.gnt_lo), 1);
    count_pulses(512, r, g, b);
    checkOutput("duty00_red", r, 0);
    checkOutput("dutyFF_green", g, 510);
    checkOutput("duty80_blue", b, 256);
    step(100);
    applyStimulus(1'b0, 24'h0, 1'b1, 24'h00FF20);
    count_pulses(412, r, g, b);
    checkOutput("old_blue_to_boundary", b, 156);
    checkOutput("green_tail", g, 410);
    count_pulses(512, r, g, b);
    checkOutput("new_blue_after_boundary", b, 64);
    checkOutput("green_full_again", g, 510);

    // Asynchronous reset mid-SHOW and mid-WARMUP
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_show", int'(out_vec), 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    checkOutput("restart_curren", int'(curren), 1);
    checkOutput("restart_rgbleden", int'(rgbleden), 0);
    step(5);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_warmup", int'(out_vec), 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    checkOutput("restart2_curren", int'(curren), 1);
    step(19);
    checkOutput("restart2_warm", int'(rgbleden), 0);
    step(1);
    checkOutput("restart2_enabled", int'(rgbleden), 1);
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    step(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
